vf_conv_canaux: RTL and testbench

- Multi-channel, parametrised fixed-point to motor-command converter for the robot datapath.
- Captures a vector of N_CH signed fixed-point values in one handshake, then emits them one channel per beat through a registered stage with valid/ready backpressure.
- Drops FRAC fractional bits and saturates. Three run-time output formats: direction+magnitude (MSB=1 positive), offset binary, or saturated two's complement.
- Sits between the control-law output and the PWM/motor drivers, replacing single-channel combinational conversion.

---
 rtl/vf_pkg.sv | 24 ++
 rtl/vf_conv_mot.sv | 75 +++++++
 rtl/vf_conv_canaux.sv | 108 ++++++++++
 tb/tb_vf_conv_canaux.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vf_pkg.sv
// Shared definitions for the multi-channel fixed-point to motor-command converter.
// Holds the output-format encodings, the sequencer states and a width helper.
package vf_pkg;

    localparam logic [1:0] MODE_DIRMAG = 2'd0;
    localparam logic [1:0] MODE_OFFSET = 2'd1;
    localparam logic [1:0] MODE_TC     = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Ceiling log2, never below 1 so a single-channel build still gets a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vf_conv_mot.sv
// Combinational conversion of one signed fixed-point value into a motor-command word:
// drop FRAC fraction bits, saturate, then encode as dir+magnitude, offset binary or two's complement.
module vf_conv_mot
    import vf_pkg::*;
#(
    parameter int W_IN  = 20,
    parameter int FRAC  = 2,
    parameter int W_OUT = 16
) (
    input  logic signed [W_IN-1:0] x,
    input  logic [1:0]             mode,
    output logic [W_OUT-1:0]       word,
    output logic                   sat
);

    // Two guard bits keep the clamp bounds representable even when W_OUT-1 == W_IN-FRAC.
    localparam int WE = W_IN + 2;
    localparam logic [WE-1:0]        ONE     = WE'(1);
    localparam logic [WE-1:0]        MAG_MAX = (ONE << (W_OUT - 1)) - ONE;
    localparam logic signed [WE-1:0] POS_MAX = $signed(MAG_MAX);
    localparam logic signed [WE-1:0] NEG_MIN = -$signed(ONE << (W_OUT - 1));

    // Returns {sat, word}; |x| is taken unsigned so the most-negative input stays exact.
    function automatic logic [W_OUT:0] sat_dirmag(input logic signed [W_IN-1:0] v);
        logic [W_IN-1:0] a;
        logic [W_IN-1:0] mag;
        logic            s;
        a   = v[W_IN-1] ? $unsigned(-v) : $unsigned(v);
        mag = a >> FRAC;
        s   = {2'b00, mag} > MAG_MAX;
        return {s, ~v[W_IN-1], (s ? {(W_OUT-1){1'b1}} : mag[W_OUT-2:0])};
    endfunction

    // Returns {sat, word}: floor shift then clamp to [-M, M-1].
    function automatic logic [W_OUT:0] sat_tc(input logic signed [W_IN-1:0] v);
        logic signed [WE-1:0] t;
        logic                 s;
        t = {{2{v[W_IN-1]}}, v};
        t = t >>> FRAC;
        s = 1'b0;
        if (t > POS_MAX) begin
            t = POS_MAX;
            s = 1'b1;
        end else if (t < NEG_MIN) begin
            t = NEG_MIN;
            s = 1'b1;
        end
        return {s, t[W_OUT-1:0]};
    endfunction

    logic [W_OUT:0] r_dm;
    logic [W_OUT:0] r_tc;

    always_comb begin
        r_dm = sat_dirmag(x);
        r_tc = sat_tc(x);
        word = r_dm[W_OUT-1:0];
        sat  = r_dm[W_OUT];
        case (mode)
            MODE_OFFSET: begin
                word = r_tc[W_OUT-1:0] ^ {1'b1, {(W_OUT-1){1'b0}}};
                sat  = r_tc[W_OUT];
            end
            MODE_TC: begin
                word = r_tc[W_OUT-1:0];
                sat  = r_tc[W_OUT];
            end
            default: begin
                word = r_dm[W_OUT-1:0];
                sat  = r_dm[W_OUT];
            end
        endcase
    end

endmodule

// File: rtl/vf_conv_canaux.sv
// Multi-channel converter: captures an N_CH vector in one handshake and streams one
// converted channel per beat through a registered valid/ready output stage.
module vf_conv_canaux
    import vf_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W_IN  = 20,
    parameter int FRAC  = 2,
    parameter int W_OUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*W_IN-1:0]     vf_in,
    input  logic [1:0]               mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [W_OUT-1:0]         out_data,
    output logic [clog2(N_CH)-1:0]   out_ch,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_CH-1:0]          sat_flags,
    input  logic                     clr_sat
);

    localparam int             CW       = clog2(N_CH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(N_CH - 1);

    state_t                  state, state_nx;
    logic [CW-1:0]           idx;
    logic [N_CH*W_IN-1:0]    vec_p0;
    logic [1:0]              mode_p0;
    logic signed [W_IN-1:0]  ch_x;
    logic [W_OUT-1:0]        conv_word;
    logic                    conv_sat;
    logic                    capture;
    logic                    load;
    logic [N_CH-1:0]         sat_set;

    assign ch_x    = vec_p0[int'(idx)*W_IN +: W_IN];
    assign load    = (state == RUN) && (!out_valid || out_ready);
    assign sat_set = (load && conv_sat) ? (N_CH'(1) << idx) : '0;

    vf_conv_mot #(
        .W_IN  (W_IN),
        .FRAC  (FRAC),
        .W_OUT (W_OUT)
    ) u_conv (
        .x    (ch_x),
        .mode (mode_p0),
        .word (conv_word),
        .sat  (conv_sat)
    );

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture  = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (load && (idx == LAST_IDX)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p0: captured vector and its output format.
    always_ff @(posedge clk) begin
        if (capture) begin
            vec_p0  <= vf_in;
            mode_p0 <= mode;
        end
    end

    // Stage p1: output register, sequencer and sticky flags; a set wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            sat_flags <= '0;
        end else begin
            state     <= state_nx;
            sat_flags <= (clr_sat ? '0 : sat_flags) | sat_set;
            if (capture) idx <= '0;
            if (load) begin
                out_data  <= conv_word;
                out_ch    <= idx;
                out_last  <= (idx == LAST_IDX);
                out_valid <= 1'b1;
                idx       <= idx + CW'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vf_conv_canaux.sv
// Self-checking bench for vf_conv_canaux: a queue-based reference model checked on every
// output handshake, plus directed literal expectations for beats, latency, flags and reset.
module tb_vf_conv_canaux;

    localparam int N_CH  = 4;
    localparam int W_IN  = 20;
    localparam int FRAC  = 2;
    localparam int W_OUT = 16;
    localparam int CW    = 2;

    logic                 clk;
    logic                 rst;
    logic [N_CH*W_IN-1:0] vf_in;
    logic [1:0]           mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [W_OUT-1:0]     out_data;
    logic [CW-1:0]        out_ch;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_CH-1:0]      sat_flags;
    logic                 clr_sat;

    vf_conv_canaux #(.N_CH(N_CH), .W_IN(W_IN), .FRAC(FRAC), .W_OUT(W_OUT)) dut (
        .clk(clk), .rst(rst), .vf_in(vf_in), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .sat_flags(sat_flags), .clr_sat(clr_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W_OUT-1:0] d;
        int               ch;
        bit               last;
        bit               s;
    } beat_t;

    beat_t            exp_q[$];
    logic [W_OUT-1:0] seen[$];
    logic [N_CH-1:0]  sat_exp;
    bit               stall;
    logic [W_OUT-1:0] hold_d;
    logic [CW-1:0]    hold_ch;
    logic             hold_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference conversion from the arithmetic rules, using plain 64-bit integers.
    function automatic logic [W_OUT-1:0] model_conv(input longint x, input int md, output bit s);
        longint m, a, v;
        m = longint'(1) << (W_OUT - 1);
        s = 1'b0;
        if (md == 1 || md == 2) begin
            v = x >>> FRAC;
            if (v > m - 1) begin v = m - 1; s = 1'b1; end
            else if (v < -m) begin v = -m; s = 1'b1; end
            v = v & (2 * m - 1);
            if (md == 1) v = v ^ m;
            return W_OUT'(v);
        end
        a = (x < 0) ? -x : x;
        a = a >> FRAC;
        if (a > m - 1) begin a = m - 1; s = 1'b1; end
        return W_OUT'(((x >= 0) ? m : 0) + a);
    endfunction

    function automatic logic [N_CH*W_IN-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [N_CH*W_IN-1:0] v;
        v[0*W_IN +: W_IN] = W_IN'(a);
        v[1*W_IN +: W_IN] = W_IN'(b);
        v[2*W_IN +: W_IN] = W_IN'(c);
        v[3*W_IN +: W_IN] = W_IN'(d);
        return v;
    endfunction

    // Monitor/scoreboard: samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            sat_exp = '0;
            stall   = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(hold_d));
                chk("hold_ch", 32'(out_ch), 32'(hold_ch));
                chk("hold_last", 32'(out_last), 32'(hold_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(out_data), 32'(e.d));
                    chk("beat_ch", 32'(out_ch), 32'(e.ch));
                    chk("beat_last", 32'(out_last), 32'(e.last));
                    if (e.s) sat_exp[e.ch] = 1'b1;
                    chk("sat_flags_run", 32'(sat_flags), 32'(sat_exp));
                end
                seen.push_back(out_data);
            end
            stall     = out_valid && !out_ready;
            hold_d    = out_data;
            hold_ch   = out_ch;
            hold_last = out_last;
            if (clr_sat) sat_exp = '0;
            if (in_valid && in_ready) begin
                for (int k = 0; k < N_CH; k++) begin
                    beat_t b;
                    bit    s;
                    b.d    = model_conv(longint'($signed(vf_in[k*W_IN +: W_IN])), int'(mode), s);
                    b.ch   = k;
                    b.last = (k == N_CH - 1);
                    b.s    = s;
                    exp_q.push_back(b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_vec(input logic [N_CH*W_IN-1:0] v, input logic [1:0] md);
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        vf_in    = v;
        mode     = md;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && (exp_q.size() != 0 || out_valid); i++) tick();
        chk("drain", 32'(exp_q.size() == 0 && !out_valid), 32'd1);
    endtask

    task automatic check_seen4(input string nm, input int base, input logic [15:0] e0,
                               input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] e[4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] a;
            a = (seen.size() > base + k) ? seen[base + k] : 16'hxxxx;
            chk(nm, 32'(a), 32'(e[k]));
        end
    endtask

    logic [N_CH*W_IN-1:0] vec_a, vec_b;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit s;
        rst = 1'b1; vf_in = '0; mode = 2'd0; in_valid = 1'b0; out_ready = 1'b1; clr_sat = 1'b0;
        vec_a = pack4(400, -400, 0, -1);
        vec_b = pack4(200000, -524288, 0, 0);
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_sat_flags", 32'(sat_flags), 32'd0);
        rst = 1'b0;

        // Literal pins on the reference model.
        chk("model_m0_pos", 32'(model_conv(400, 0, s)), 32'h8064);
        chk("model_m0_neg1", 32'(model_conv(-1, 0, s)), 32'h0000);
        chk("model_m0_zero", 32'(model_conv(0, 0, s)), 32'h8000);
        chk("model_m1_neg", 32'(model_conv(-400, 1, s)), 32'h7F9C);
        chk("model_m2_neg", 32'(model_conv(-400, 2, s)), 32'hFF9C);
        chk("model_m2_nosat", 32'(s), 32'd0);
        chk("model_m2_neg1", 32'(model_conv(-1, 2, s)), 32'hFFFF);
        chk("model_m1_satpos", 32'(model_conv(200000, 1, s)), 32'hFFFF);
        chk("model_m1_satflag", 32'(s), 32'd1);
        chk("model_m0_mostneg", 32'(model_conv(-524288, 0, s)), 32'h7FFF);
        chk("model_m2_mostneg", 32'(model_conv(-524288, 2, s)), 32'h8000);
        chk("model_m3_as_m0", 32'(model_conv(400, 3, s)), 32'h8064);

        // Mode 0 basic stream with latency.
        seen.delete();
        send_vec(vec_a, 2'd0);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_first_data", 32'(out_data), 32'h8064);
        wait_drain();
        check_seen4("m0_beats", 0, 16'h8064, 16'h0064, 16'h8000, 16'h0000);
        chk("m0_sat_flags", 32'(sat_flags), 32'd0);

        seen.delete(); send_vec(vec_a, 2'd1); wait_drain();
        check_seen4("m1_beats", 0, 16'h8064, 16'h7F9C, 16'h8000, 16'h7FFF);
        seen.delete(); send_vec(vec_a, 2'd2); wait_drain();
        check_seen4("m2_beats", 0, 16'h0064, 16'hFF9C, 16'h0000, 16'hFFFF);
        seen.delete(); send_vec(vec_a, 2'd3); wait_drain();
        check_seen4("m3_beats", 0, 16'h8064, 16'h0064, 16'h8000, 16'h0000);

        // Saturation and sticky flags.
        seen.delete(); send_vec(vec_b, 2'd0); wait_drain();
        check_seen4("sat_m0_beats", 0, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000);
        chk("sat_flags_m0", 32'(sat_flags), 32'h3);
        seen.delete(); send_vec(vec_b, 2'd1); wait_drain();
        check_seen4("sat_m1_beats", 0, 16'hFFFF, 16'h0000, 16'h8000, 16'h8000);
        seen.delete(); send_vec(vec_b, 2'd2); wait_drain();
        check_seen4("sat_m2_beats", 0, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000);
        tick(); tick();
        chk("sat_flags_sticky", 32'(sat_flags), 32'h3);
        clr_sat = 1'b1; tick(); clr_sat = 1'b0;
        chk("sat_flags_clr", 32'(sat_flags), 32'h0);

        // Backpressure on the ch1 beat.
        seen.delete();
        send_vec(vec_a, 2'd2);
        tick(); tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ch", 32'(out_ch), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        wait_drain();
        check_seen4("bp_beats", 0, 16'h0064, 16'hFF9C, 16'h0000, 16'hFFFF);
        chk("bp_count", 32'(seen.size()), 32'd4);

        // Reset in the middle of a vector.
        seen.delete();
        send_vec(vec_b, 2'd0);
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_sat_flags", 32'(sat_flags), 32'd0);
        seen.delete(); send_vec(vec_a, 2'd0); wait_drain();
        check_seen4("post_rst_beats", 0, 16'h8064, 16'h0064, 16'h8000, 16'h0000);

        // Back-to-back vectors with a mode change between them.
        seen.delete();
        send_vec(vec_a, 2'd0);
        send_vec(vec_a, 2'd2);
        chk("b2b_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_first_ch", 32'(out_ch), 32'd0);
        chk("b2b_first_data", 32'(out_data), 32'h0064);
        wait_drain();
        check_seen4("b2b_vec1", 0, 16'h8064, 16'h0064, 16'h8000, 16'h0000);
        check_seen4("b2b_vec2", 4, 16'h0064, 16'hFF9C, 16'h0000, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
